// File: rtl/pci_master_dma.sv
// DMA initiator front-end for a PCI core: moves dma_len words between a local
// buffer and PCI memory, restarting after target disconnects up to MAX_RETRY times.
module pci_master_dma #(
  parameter int MAX_RETRY = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_start,
  input  logic [31:0] dma_addr,
  input  logic [9:0]  dma_len,
  input  logic        dma_wr,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_err,
  output logic        int_n,
  input  logic        int_clr,
  input  logic [31:0] buf_data,
  input  logic        buf_empty,
  output logic        buf_rd,
  output logic [31:0] buf_wdata,
  output logic        buf_we,
  input  logic        buf_full,
  output logic        request,
  output logic        requesthold,
  output logic        complete,
  output logic        m_ready,
  output logic        m_wrdn,
  output logic [3:0]  m_cbe,
  output logic [31:0] adio_in,
  input  logic [31:0] adio_out,
  input  logic        m_addr_n,
  input  logic        m_data,
  input  logic        m_data_vld,
  input  logic        m_src_en,
  input  logic        m_abort
);

  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, DONE, ERR} state_t;

  state_t         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [9:0]     rem_q, rem_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           dir_q, dir_d;
  logic           abort_q, abort_d;
  logic           pend_q, pend_d;
  logic           mdata_q;
  logic           xfer_end;

  // The core signals the end of a transaction by dropping m_data.
  assign xfer_end = (state_q == DATA) && mdata_q && !m_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      retry_q <= '0;
      dir_q   <= 1'b0;
      abort_q <= 1'b0;
      pend_q  <= 1'b0;
      mdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      retry_q <= retry_d;
      dir_q   <= dir_d;
      abort_q <= abort_d;
      pend_q  <= pend_d;
      mdata_q <= m_data;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    retry_d = retry_q;
    dir_d   = dir_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        if (dma_start) begin
          if (dma_len != 10'd0) begin
            addr_d  = dma_addr & 32'hFFFF_FFFC;
            rem_d   = dma_len;
            dir_d   = dma_wr;
            retry_d = '0;
            state_d = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        abort_d = 1'b0;
        state_d = ADDR;
      end
      ADDR: begin
        if (m_abort) abort_d = 1'b1;
        if (!m_addr_n) state_d = DATA;
      end
      DATA: begin
        if (m_abort) abort_d = 1'b1;
        if (m_data_vld) begin
          rem_d  = rem_q - 10'd1;
          addr_d = addr_q + 32'd4;
        end
        // Abort outranks a finished count; a disconnect with words left retries.
        if (xfer_end) begin
          if (abort_q || m_abort)             state_d = ERR;
          else if (rem_d == 10'd0)            state_d = DONE;
          else if (retry_q == RW'(MAX_RETRY)) state_d = ERR;
          else begin
            retry_d = retry_q + RW'(1);
            state_d = REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new interrupt set wins over a coincident clear.
  always_comb begin
    pend_d = pend_q;
    if (int_clr) pend_d = 1'b0;
    if (state_q == DONE || state_q == ERR) pend_d = 1'b1;
  end

  always_comb begin
    request  = 1'b0;
    complete = 1'b0;
    m_ready  = 1'b0;
    m_wrdn   = 1'b0;
    m_cbe    = 4'h0;
    adio_in  = 32'h0;
    buf_rd   = 1'b0;
    buf_we   = 1'b0;
    case (state_q)
      REQ, ADDR: begin
        request = (state_q == REQ);
        adio_in = addr_q;
        m_cbe   = dir_q ? 4'h7 : 4'h6;
        m_wrdn  = dir_q;
      end
      DATA: begin
        m_wrdn   = dir_q;
        m_ready  = dir_q ? !buf_empty : !buf_full;
        complete = (rem_q <= 10'd1);
        if (dir_q) begin
          adio_in = buf_data;
          buf_rd  = m_src_en;
        end else begin
          buf_we  = m_data_vld;
        end
      end
      default: ;
    endcase
  end

  assign buf_wdata   = adio_out;
  assign requesthold = 1'b0;
  assign dma_busy    = (state_q != IDLE);
  assign dma_done    = (state_q == DONE);
  assign dma_err     = (state_q == ERR);
  assign int_n       = !pend_q;

endmodule
